plot_port_arbiter: RTL and testbench
====================================

// Module: plot_port_arbiter
// PURPOSE
//  Shares the single vga_adapter pixel-write port (x, y, colour, plot) among NUM_REQ pixel
//  producers: sprite datapath, game-over text overlay, HUD/score overlay.
//  Round-robin grant with optional burst lock and a starvation cap. Also contains a
//  full-screen clear engine that pre-empts all requesters. Registered output stage
//  drives vga_adapter directly.
// PARAMETERS
//  NUM_REQ   3      number of requesters (1..4)
//  H_RES     160    screen width in pixels
//  V_RES     120    screen height in pixels
//  COL_W     24     colour width (8 bits/channel)
//  LOCK_MAX  64     max consecutive grant cycles for one locked requester
// PORTS
//  clk           in   1              system clock (CLOCK_50)
//  resetn        in   1              asynchronous, active-low reset
//  clear_start   in   1              1-cycle pulse: begin full-screen clear
//  clear_colour  in   COL_W          fill colour, sampled on accepted clear_start
//  clear_busy    out  1              high while the clear sweep runs
//  req_valid     in   NUM_REQ        requester i has a pixel to write
//  req_lock      in   NUM_REQ        requester i requests to keep the grant (burst)
//  req_x         in   8*NUM_REQ      packed x; requester i at [8i+7:8i]
//  req_y         in   8*NUM_REQ      packed y; requester i at [8i+7:8i]
//  req_colour    in   COL_W*NUM_REQ  packed colour, same packing
//  req_ready     out  NUM_REQ        one-hot or zero; pixel i accepted when valid&ready
//  grant_id      out  2              index of current grant; 0 when no grant
//  plot_x        out  8              to vga_adapter x
//  plot_y        out  8              to vga_adapter y
//  plot_colour   out  COL_W          to vga_adapter colour
//  plot          out  1              to vga_adapter plot
// BEHAVIOUR
//  Reset: plot=0, plot_x=plot_y=0, plot_colour=0, clear_busy=0, req_ready=0, grant_id=0,
//   rr pointer=0, lock counter=0, clear engine idle. Reset mid-clear aborts the sweep.
//  Grant (combinational from regs+inputs): if clear_busy -> req_ready=0.
//   Else if a lock owner exists -> it holds the grant (ready high only when it is valid).
//   Else the first valid requester searching ptr, ptr+1, ... (mod NUM_REQ) is granted.
//  Lock: owner is set when a granted requester transfers with req_lock=1. Owner keeps the
//   grant while its req_lock=1, even on cycles with valid=0 (bubbles allowed; no other
//   requester is granted). The lock releases when req_lock=0 or when the counter reaches
//   LOCK_MAX consecutive owned cycles. A forced release makes the owner ineligible to
//   re-lock until one other requester transfers, or no other requester is valid.
//  Pointer: after a transfer by i with no lock retained, ptr <= (i+1) mod NUM_REQ.
//   On lock release, ptr <= owner+1.
//  Output stage: an accepted pixel appears on plot_x/plot_y/plot_colour with plot=1 on
//   the NEXT clk edge (latency 1). plot=0 on cycles with no transfer. Throughput is
//   1 pixel/cycle. Coordinates outside H_RES/V_RES are forwarded unchanged; clipping is
//   the adapter's job.
//  Clear engine states:
//   IDLE -> SWEEP on clear_start.
//   SWEEP: emits (x,y) raster order, x fastest, 0..H_RES-1, 0..V_RES-1, one pixel per
//    cycle, colour=clear_colour latched.
//   SWEEP -> IDLE after pixel (H_RES-1, V_RES-1).
//   Total H_RES*V_RES cycles (19200 default). clear_busy goes high the cycle after
//   clear_start and drops after the last pixel is issued.
//   clear_start while busy is ignored (no restart).
//   clear_start in the same cycle as a requester transfer: the transfer completes;
//   clear output begins the following cycle.
//   A lock owner's lock is cancelled on clear start; its counter is reset.
//  Arithmetic: x/y counters are 8-bit. The lock counter is clog2(LOCK_MAX+1) bits and
//   saturates. No wrap is permitted past the final pixel.
// STRUCTURE
//  Shared package/include: H_RES, V_RES, COL_W, colour constants (BLACK, WHITE); the same
//  values feed vga_adapter defparams.
//  Sub-module: screen_clear_sequencer (x/y raster counters, busy flag, latched colour,
//  done pulse).
//  The arbiter core, lock logic and output register stay in this module.
// TESTING
//  1 req0 and req2 valid continuously, no lock, ptr=0 -> grants alternate 0,2,0,2;
//    plot=1 every cycle with one-cycle lag.
//  2 req1 lock=1 for 10 pixels with 2 bubble cycles, req0 valid -> req0 ready=0 for all
//    12 cycles; req0 is granted on the cycle after lock drops.
//  3 LOCK_MAX=64, req0 locks forever, req1 valid -> forced release after 64 cycles;
//    req1 granted next; req0 regains the grant only without a lock until req1 transfers.
//  4 clear_start with colour 24'hFFFFFF -> exactly 19200 plot pulses (0,0)..(159,119) in
//    order; req_ready=0 throughout; clear_busy falls after the last pixel.
//  5 second clear_start mid-sweep -> ignored; count remains 19200.
//    resetn low at pixel 5000 -> plot=0 and clear_busy=0 immediately.
//  6 all req_valid=0 -> plot=0 and grant_id=0. A single pixel (37,90,24'h00FF00) from req2
//    -> exactly one plot cycle with those values.

Source files
------------

// File: rtl/plot_port_arbiter_pkg.sv
// Shared screen geometry, colour constants and clear-engine state type.
// The same geometry values feed the vga_adapter defparams.
package plot_port_arbiter_pkg;

    localparam int H_RES = 160;
    localparam int V_RES = 120;
    localparam int COL_W = 24;

    localparam logic [COL_W-1:0] BLACK = 24'h000000;
    localparam logic [COL_W-1:0] WHITE = 24'hFFFFFF;

    typedef enum logic {
        CLR_IDLE,
        CLR_SWEEP
    } clr_state_t;

    function automatic logic [1:0] wrap_inc(input logic [1:0] i, input int n);
        logic [2:0] s;
        s = {1'b0, i} + 3'd1;
        if (int'(s) >= n) s = '0;
        return s[1:0];
    endfunction

endpackage

// File: rtl/plot_port_arbiter_clear.sv
// Full-screen clear sequencer: raster x/y counters, busy flag,
// latched fill colour and a done pulse on the final pixel.
module screen_clear_sequencer #(
    parameter int H_RES = plot_port_arbiter_pkg::H_RES,
    parameter int V_RES = plot_port_arbiter_pkg::V_RES,
    parameter int COL_W = plot_port_arbiter_pkg::COL_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [COL_W-1:0] colour_i,
    output logic             busy_o,
    output logic [7:0]       x_o,
    output logic [7:0]       y_o,
    output logic [COL_W-1:0] colour_o,
    output logic             done_o
);
    import plot_port_arbiter_pkg::*;

    clr_state_t       state_q, state_d;
    logic [7:0]       x_q, x_d, y_q, y_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             x_end, last;

    assign x_end = (x_q == 8'(H_RES - 1));
    assign last  = x_end && (y_q == 8'(V_RES - 1));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        done_o  = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (start_i) begin
                    state_d = CLR_SWEEP;
                    x_d     = '0;
                    y_d     = '0;
                    col_d   = colour_i;
                end
            end
            CLR_SWEEP: begin
                if (last) begin
                    state_d = CLR_IDLE;
                    done_o  = 1'b1;
                end else if (x_end) begin
                    x_d = '0;
                    y_d = y_q + 8'd1;
                end else begin
                    x_d = x_q + 8'd1;
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= CLR_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= BLACK;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
        end
    end

    assign busy_o   = (state_q == CLR_SWEEP);
    assign x_o      = x_q;
    assign y_o      = y_q;
    assign colour_o = col_q;

endmodule

// File: rtl/plot_port_arbiter.sv
// Round-robin arbiter with burst lock and starvation cap sharing the
// vga_adapter pixel port; a clear sweep pre-empts every requester.
module plot_port_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int H_RES    = plot_port_arbiter_pkg::H_RES,
    parameter int V_RES    = plot_port_arbiter_pkg::V_RES,
    parameter int COL_W    = plot_port_arbiter_pkg::COL_W,
    parameter int LOCK_MAX = 64
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear_start,
    input  logic [COL_W-1:0]         clear_colour,
    output logic                     clear_busy,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_lock,
    input  logic [8*NUM_REQ-1:0]     req_x,
    input  logic [8*NUM_REQ-1:0]     req_y,
    input  logic [COL_W*NUM_REQ-1:0] req_colour,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [1:0]               grant_id,
    output logic [7:0]               plot_x,
    output logic [7:0]               plot_y,
    output logic [COL_W-1:0]         plot_colour,
    output logic                     plot
);
    import plot_port_arbiter_pkg::*;

    localparam int CW = $clog2(LOCK_MAX + 1);

    logic             clr_go, clr_done;
    logic [7:0]       clr_x, clr_y;
    logic [COL_W-1:0] clr_col;

    logic [1:0]    ptr_q, ptr_d, own_id_q, own_id_d, inel_id_q, inel_id_d;
    logic          own_q, own_d, inel_q, inel_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic             plot_q, plot_d;
    logic [7:0]       x_q, x_d, y_q, y_d;
    logic [COL_W-1:0] col_q, col_d;

    logic [1:0]       gid, idx;
    logic             found, other_v, may_lock;
    logic [7:0]       sel_x, sel_y;
    logic [COL_W-1:0] sel_c;

    assign clr_go = clear_start && !clear_busy;

    screen_clear_sequencer #(
        .H_RES(H_RES),
        .V_RES(V_RES),
        .COL_W(COL_W)
    ) u_clear (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (clear_start),
        .colour_i(clear_colour),
        .busy_o  (clear_busy),
        .x_o     (clr_x),
        .y_o     (clr_y),
        .colour_o(clr_col),
        .done_o  (clr_done)
    );

    // Lock owner overrides the round-robin search; found == transfer.
    always_comb begin
        gid       = '0;
        found     = 1'b0;
        idx       = ptr_q;
        req_ready = '0;
        if (!clear_busy) begin
            if (own_q) begin
                gid   = own_id_q;
                found = req_valid[own_id_q];
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (!found && req_valid[idx]) begin
                        gid   = idx;
                        found = 1'b1;
                    end
                    idx = wrap_inc(idx, NUM_REQ);
                end
            end
            req_ready[gid] = found;
        end
    end

    assign grant_id = gid;

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gid == 2'(i)) begin
                sel_x = req_x[8*i +: 8];
                sel_y = req_y[8*i +: 8];
                sel_c = req_colour[COL_W*i +: COL_W];
            end
        end
    end

    always_comb begin
        other_v = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (2'(i) != inel_id_q && req_valid[i]) other_v = 1'b1;
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        own_d     = own_q;
        own_id_d  = own_id_q;
        cnt_d     = cnt_q;
        inel_d    = inel_q;
        inel_id_d = inel_id_q;
        may_lock  = !(inel_q && inel_id_q == gid && other_v);
        if (inel_q && (!other_v || (found && gid != inel_id_q) || clr_done))
            inel_d = 1'b0;
        if (own_q) begin
            cnt_d = (cnt_q == CW'(LOCK_MAX)) ? cnt_q : cnt_q + CW'(1);
            if (!req_lock[own_id_q]) begin
                own_d = 1'b0;
                cnt_d = '0;
                ptr_d = wrap_inc(own_id_q, NUM_REQ);
            end else if (cnt_d == CW'(LOCK_MAX)) begin
                own_d     = 1'b0;
                cnt_d     = '0;
                ptr_d     = wrap_inc(own_id_q, NUM_REQ);
                inel_d    = 1'b1;
                inel_id_d = own_id_q;
            end
        end else if (found) begin
            if (req_lock[gid] && may_lock) begin
                own_d    = 1'b1;
                own_id_d = gid;
                cnt_d    = CW'(1);
            end else begin
                ptr_d = wrap_inc(gid, NUM_REQ);
            end
        end
        if (clr_go) begin
            own_d  = 1'b0;
            cnt_d  = '0;
            inel_d = 1'b0;
        end
    end

    always_comb begin
        plot_d = 1'b0;
        x_d    = x_q;
        y_d    = y_q;
        col_d  = col_q;
        unique case (1'b1)
            clear_busy: begin
                plot_d = 1'b1;
                x_d    = clr_x;
                y_d    = clr_y;
                col_d  = clr_col;
            end
            found: begin
                plot_d = 1'b1;
                x_d    = sel_x;
                y_d    = sel_y;
                col_d  = sel_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q     <= '0;
            own_q     <= 1'b0;
            own_id_q  <= '0;
            cnt_q     <= '0;
            inel_q    <= 1'b0;
            inel_id_q <= '0;
            plot_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            col_q     <= BLACK;
        end else begin
            ptr_q     <= ptr_d;
            own_q     <= own_d;
            own_id_q  <= own_id_d;
            cnt_q     <= cnt_d;
            inel_q    <= inel_d;
            inel_id_q <= inel_id_d;
            plot_q    <= plot_d;
            x_q       <= x_d;
            y_q       <= y_d;
            col_q     <= col_d;
        end
    end

    assign plot        = plot_q;
    assign plot_x      = x_q;
    assign plot_y      = y_q;
    assign plot_colour = col_q;

endmodule

// File: tb/tb_plot_port_arbiter.sv
// Bench for plot_port_arbiter: directed vectors plus a per-cycle
// reference model of grant, lock, clear sweep and output stage.
module tb_plot_port_arbiter;

    localparam int N  = 3;
    localparam int H  = 160;
    localparam int V  = 120;
    localparam int LM = 64;

    logic        clk, resetn, clear_start;
    logic [23:0] clear_colour;
    logic        clear_busy;
    logic [2:0]  rv, rl;
    logic [23:0] rx, ry;
    logic [71:0] rc;
    logic [2:0]  req_ready;
    logic [1:0]  grant_id;
    logic [7:0]  plot_x, plot_y;
    logic [23:0] plot_colour;
    logic        plot;

    int checks = 0;
    int errors = 0;

    plot_port_arbiter #(
        .NUM_REQ(N), .H_RES(H), .V_RES(V), .COL_W(24), .LOCK_MAX(LM)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .clear_start (clear_start),
        .clear_colour(clear_colour),
        .clear_busy  (clear_busy),
        .req_valid   (rv),
        .req_lock    (rl),
        .req_x       (rx),
        .req_y       (ry),
        .req_colour  (rc),
        .req_ready   (req_ready),
        .grant_id    (grant_id),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .plot        (plot)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    // Reference model: ptr/owner as plain ints, clear as a pixel index.
    int          m_ptr, m_own, m_cnt, m_inel, m_n, g;
    bit          m_busy, cur_busy, m_plot, oth, elig;
    logic [7:0]  m_px, m_py;
    logic [23:0] m_pc, m_ccol;
    logic [2:0]  er;
    logic [1:0]  eg;

    always @(negedge clk) begin
        if (!resetn) begin
            m_ptr = 0; m_own = -1; m_cnt = 0; m_inel = -1;
            m_busy = 0; m_n = 0; m_ccol = '0;
            m_plot = 0; m_px = '0; m_py = '0; m_pc = '0;
            chk("rst_plot", 32'(plot), 0);
            chk("rst_busy", 32'(clear_busy), 0);
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_gid", 32'(grant_id), 0);
        end else begin
            g = -1;
            eg = '0;
            cur_busy = m_busy;
            if (!m_busy) begin
                if (m_own >= 0) begin
                    eg = 2'(m_own);
                    if (rv[m_own]) g = m_own;
                end else begin
                    for (int k = 0; k < N; k++)
                        if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            er = '0;
            if (g >= 0) begin
                er[g] = 1'b1;
                eg = 2'(g);
            end
            chk("m_ready", 32'(req_ready), 32'(er));
            chk("m_gid", 32'(grant_id), 32'(eg));
            chk("m_busy", 32'(clear_busy), 32'(m_busy));
            chk("m_plot", 32'(plot), 32'(m_plot));
            if (m_plot) begin
                chk("m_x", 32'(plot_x), 32'(m_px));
                chk("m_y", 32'(plot_y), 32'(m_py));
                chk("m_col", 32'(plot_colour), 32'(m_pc));
            end
            if (m_busy) begin
                m_plot = 1; m_pc = m_ccol;
                m_px = 8'(m_n % H); m_py = 8'(m_n / H);
                m_n++;
                if (m_n == H * V) m_busy = 0;
            end else if (g >= 0) begin
                m_plot = 1;
                m_px = rx[8*g +: 8]; m_py = ry[8*g +: 8]; m_pc = rc[24*g +: 24];
            end else begin
                m_plot = 0;
            end
            oth = 0;
            for (int i = 0; i < N; i++) if (i != m_inel && rv[i]) oth = 1;
            elig = !(m_inel >= 0 && g == m_inel && oth);
            if (m_inel >= 0 && (!oth || (g >= 0 && g != m_inel))) m_inel = -1;
            if (m_own >= 0) begin
                m_cnt++;
                if (!rl[m_own]) begin
                    m_ptr = (m_own + 1) % N; m_own = -1; m_cnt = 0;
                end else if (m_cnt >= LM) begin
                    m_ptr = (m_own + 1) % N; m_inel = m_own;
                    m_own = -1; m_cnt = 0;
                end
            end else if (g >= 0) begin
                if (rl[g] && elig) begin
                    m_own = g; m_cnt = 1;
                end else begin
                    m_ptr = (g + 1) % N;
                end
            end
            if (clear_start && !cur_busy) begin
                m_busy = 1; m_n = 0; m_ccol = clear_colour;
                m_own = -1; m_cnt = 0; m_inel = -1;
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [7:0] x, input logic [7:0] y,
                           input logic [23:0] c);
        rv[i] = v; rl[i] = l;
        rx[8*i +: 8] = x; ry[8*i +: 8] = y; rc[24*i +: 24] = c;
    endtask

    task automatic run_clear(input logic [23:0] col, input int inj_at,
                             input int rst_at, input int xfer_x,
                             output int cnt, output int bad, output int rb);
        bit pb;
        int c;
        cnt = 0; bad = 0; rb = 0; c = 0;
        clear_colour = col;
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        clear_colour = ~col;
        chk("clr_busy_rise", 32'(clear_busy), 1);
        if (xfer_x >= 0) begin
            chk("clr_xfer_plot", 32'(plot), 1);
            chk("clr_xfer_x", 32'(plot_x), 32'(xfer_x));
        end
        pb = clear_busy;
        while (pb && c < 20000) begin
            c++;
            if (clear_busy && req_ready != 3'b000) rb++;
            @(posedge clk); #1;
            clear_start = 1'b0;
            if (pb && plot) begin
                if (plot_x != 8'(cnt % H) || plot_y != 8'(cnt / H) ||
                    plot_colour != col) bad++;
                cnt++;
            end
            if (cnt == inj_at) clear_start = 1'b1;
            if (cnt == rst_at) begin
                resetn = 1'b0;
                #1;
                chk("rst_mid_plot", 32'(plot), 0);
                chk("rst_mid_busy", 32'(clear_busy), 0);
                pb = 0;
            end else begin
                pb = clear_busy;
            end
        end
        if (c >= 20000) begin
            checks++;
            errors++;
            $display("FAIL clr_timeout pixels=%0d required=%0d", cnt, H * V);
        end
    endtask

    int n, cnt, bad, rb;
    int pat[12] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1};

    initial begin
        resetn = 1'b0; clear_start = 1'b0; clear_colour = '0;
        rv = '0; rl = '0; rx = '0; ry = '0; rc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_plot", 32'(plot), 0);
        chk("reset_x", 32'(plot_x), 0);
        chk("reset_col", 32'(plot_colour), 0);
        chk("reset_busy", 32'(clear_busy), 0);
        resetn = 1'b1;

        // idle, then one pixel from req2
        repeat (2) begin
            @(posedge clk); #1;
            chk("t6_idle_plot", 32'(plot), 0);
            chk("t6_idle_gid", 32'(grant_id), 0);
        end
        set_req(2, 1, 0, 8'd37, 8'd90, 24'h00FF00);
        #1;
        chk("t6_ready", 32'(req_ready), 32'b100);
        chk("t6_gid", 32'(grant_id), 2);
        @(posedge clk); #1;
        set_req(2, 0, 0, 8'd0, 8'd0, 24'h0);
        chk("t6_plot", 32'(plot), 1);
        chk("t6_x", 32'(plot_x), 37);
        chk("t6_y", 32'(plot_y), 90);
        chk("t6_col", 32'(plot_colour), 32'h00FF00);
        n = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (plot) n++;
        end
        chk("t6_single", n, 0);

        // req0 and req2 alternate
        set_req(0, 1, 0, 8'd10, 8'd1, 24'h0000AA);
        set_req(2, 1, 0, 8'd12, 8'd3, 24'h0000CC);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t1_gid", 32'(grant_id), (k % 2 == 0) ? 0 : 2);
            @(posedge clk); #1;
            chk("t1_plot", 32'(plot), 1);
            chk("t1_x", 32'(plot_x), (k % 2 == 0) ? 10 : 12);
        end
        set_req(0, 0, 0, 8'd0, 8'd0, 24'h0);
        set_req(2, 0, 0, 8'd0, 8'd0, 24'h0);

        // req1 burst lock with bubbles blocks req0
        set_req(0, 1, 0, 8'd20, 8'd5, 24'h000011);
        #1;
        chk("t2_pre", 32'(req_ready), 32'b001);
        @(posedge clk); #1;
        set_req(1, 1, 1, 8'd50, 8'd9, 24'h000099);
        for (int k = 0; k < 12; k++) begin
            rv[1] = pat[k][0];
            rl[1] = 1'b1;
            #1;
            chk("t2_r0_blocked", 32'(req_ready[0]), 0);
            if (k == 0) chk("t2_r1_first", 32'(req_ready), 32'b010);
            @(posedge clk); #1;
        end
        rv[1] = 1'b0; rl[1] = 1'b0;
        #1;
        chk("t2_drop_r0", 32'(req_ready[0]), 0);
        chk("t2_drop_gid", 32'(grant_id), 1);
        @(posedge clk); #1;
        chk("t2_r0_after", 32'(req_ready), 32'b001);
        @(posedge clk); #1;
        set_req(0, 0, 0, 8'd0, 8'd0, 24'h0);

        // forced release after LOCK_MAX owned cycles
        set_req(0, 1, 1, 8'd30, 8'd6, 24'h000022);
        #1;
        chk("t3_acquire", 32'(req_ready), 32'b001);
        @(posedge clk); #1;
        set_req(1, 1, 0, 8'd31, 8'd7, 24'h000033);
        #1;
        n = 1;
        while (req_ready == 3'b001 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        chk("t3_hold", n, LM);
        chk("t3_r1_next", 32'(req_ready), 32'b010);
        @(posedge clk); #1;
        chk("t3_regain", 32'(req_ready), 32'b001);
        set_req(0, 0, 0, 8'd0, 8'd0, 24'h0);
        set_req(1, 0, 0, 8'd0, 8'd0, 24'h0);
        repeat (3) begin
            @(posedge clk); #1;
        end

        // full clear with a same-cycle transfer from req1
        set_req(1, 1, 0, 8'd40, 8'd8, 24'h000044);
        #1;
        chk("t4_same_cycle", 32'(req_ready), 32'b010);
        run_clear(24'hFFFFFF, -1, -1, 40, cnt, bad, rb);
        chk("t4_count", cnt, H * V);
        chk("t4_order", bad, 0);
        chk("t4_ready_low", rb, 0);
        chk("t4_after", 32'(req_ready), 32'b010);
        set_req(1, 0, 0, 8'd0, 8'd0, 24'h0);
        @(posedge clk); #1;

        // second start mid-sweep is ignored
        run_clear(24'h123456, 3000, -1, -1, cnt, bad, rb);
        chk("t5_ignore_count", cnt, H * V);
        chk("t5_ignore_order", bad, 0);
        @(posedge clk); #1;

        // reset aborts the sweep
        run_clear(24'h654321, -1, 5000, -1, cnt, bad, rb);
        chk("t5_rst_count", cnt, 5000);
        chk("t5_rst_order", bad, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        set_req(0, 1, 0, 8'd1, 8'd2, 24'h000001);
        set_req(2, 1, 0, 8'd3, 8'd4, 24'h000003);
        #1;
        chk("t5_ptr_reset", 32'(grant_id), 0);
        @(posedge clk); #1;
        set_req(0, 0, 0, 8'd0, 8'd0, 24'h0);
        set_req(2, 0, 0, 8'd0, 8'd0, 24'h0);
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
